// File: rtl/serial_pair_adder.sv
// Multi-cycle WIDTH-bit adder built from one reused two-bit full-adder slice.
// One digit pair per clock, LSB first; operands in and result out over valid/ready.

module two_bit_full_adder (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};

endmodule

module serial_pair_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("serial_pair_adder: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_next_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       slice_sum_s;
  logic             slice_cout_s;

  two_bit_full_adder u_slice (
    .A   (a_sh_r[1:0]),
    .B   (b_sh_r[1:0]),
    .Cin (carry_r),
    .S   (slice_sum_s),
    .Cout(slice_cout_s)
  );

  // Next sum shift value: new digit enters at the top, older digits move down
  always_comb begin
    sum_next_s = sum_sh_r >> 2'd2;
    sum_next_s[WIDTH-1 -: 2] = slice_sum_s;
  end

  // Handshake FSM and serial datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            carry_r    <= cin;
            cnt_r      <= '0;
            a_msb_r    <= a[WIDTH-1];
            b_msb_r    <= b[WIDTH-1];
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> 2'd2;
          b_sh_r   <= b_sh_r >> 2'd2;
          sum_sh_r <= sum_next_s;
          carry_r  <= slice_cout_s;
          cnt_r    <= cnt_r + 1'b1;
          if (cnt_r == LAST) begin
            // The last slice produces the sum MSB, so overflow is decided here
            ovf_r       <= (a_msb_r == b_msb_r) && (slice_sum_s[1] != a_msb_r);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_sh_r;
  assign cout      = carry_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_pair_adder.sv
// Directed checks of serial_pair_adder at WIDTH=8 plus an exhaustive WIDTH=4
// sweep with random output stalls.

module tb_serial_pair_adder;

  logic       clock;
  logic       reset_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int nvec = 0;
  int nerr = 0;

  serial_pair_adder #(.WIDTH(8)) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .sum      (sum8),
    .cout     (cout8),
    .ovf      (ovf8)
  );

  serial_pair_adder #(.WIDTH(4)) dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .a        (a4),
    .b        (b4),
    .cin      (cin4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .sum      (sum4),
    .cout     (cout4),
    .ovf      (ovf4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one operand set to the 8-bit DUT; returns once it is accepted
  task automatic send8(input logic [7:0] va, input logic [7:0] vb, input logic vc, input string tag);
    int n;
    n = 0;
    while (!in_ready8 && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_ready_timeout"}, 32'(n < 20), 32'd1);
    a8 = va; b8 = vb; cin8 = vc; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  // Full transaction with latency and result checks, then drain
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    send8(va, vb, vc, tag);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      tick();
      lat++;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'd4);
    check_val({tag, "_sum"}, 32'(sum8), 32'(es));
    check_val({tag, "_cout"}, 32'(cout8), 32'(ec));
    check_val({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check_val({tag, "_drain_valid"}, 32'(out_valid8), 32'd0);
    check_val({tag, "_drain_ready"}, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    logic [5:0] exp_q[$];
    logic [5:0] exp4, got4;
    logic [4:0] full4;
    logic [8:0] idx;
    int sent, got, cyc, n;
    bit acc, del;

    reset_n = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; out_ready4 = 1'b0;
    repeat (3) tick();

    check_val("rst_in_ready", 32'(in_ready8), 32'd1);
    check_val("rst_out_valid", 32'(out_valid8), 32'd0);
    check_val("rst_sum", 32'(sum8), 32'd0);
    check_val("rst_cout", 32'(cout8), 32'd0);
    check_val("rst_ovf", 32'(ovf8), 32'd0);
    reset_n = 1'b1;
    tick();

    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ripple");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "fullscale");
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "negovf");
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "posovf");
    run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cinonly");

    // Backpressure: result held, new operands ignored while DONE
    send8(8'h12, 8'h34, 1'b1, "bp");
    n = 0;
    while (!out_valid8 && n < 20) begin
      tick();
      n++;
    end
    check_val("bp_wait", 32'(n), 32'd4);
    in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA; cin8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", 32'(out_valid8), 32'd1);
      check_val("bp_in_ready", 32'(in_ready8), 32'd0);
      check_val("bp_sum", 32'(sum8), 32'h47);
      check_val("bp_cout", 32'(cout8), 32'd0);
      check_val("bp_ovf", 32'(ovf8), 32'd0);
      tick();
    end
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    check_val("bp_release_ready", 32'(in_ready8), 32'd1);
    check_val("bp_release_valid", 32'(out_valid8), 32'd0);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "after_bp");

    // Reset two cycles into RUN aborts the operation asynchronously
    send8(8'h55, 8'h55, 1'b0, "abort");
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_in_ready", 32'(in_ready8), 32'd1);
    check_val("abort_out_valid", 32'(out_valid8), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    out_ready8 = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid8) n++;
      tick();
    end
    out_ready8 = 1'b0;
    check_val("abort_no_result", 32'(n), 32'd0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset");

    // Exhaustive WIDTH=4 with random consumer stalls
    sent = 0; got = 0; cyc = 0;
    while (got < 512 && cyc < 20000) begin
      out_ready4 = ($urandom_range(0, 3) != 0);
      in_valid4 = (sent < 512);
      idx = 9'(sent);
      {cin4, a4, b4} = idx;
      acc = in_valid4 && in_ready4;
      del = out_valid4 && out_ready4;
      if (del) begin
        got4 = {ovf4, cout4, sum4};
        if (exp_q.size() == 0) begin
          check_val("exh_dup", 32'(got4), 32'hFFFF);
        end else begin
          exp4 = exp_q.pop_front();
          check_val("exh_result", 32'(got4), 32'(exp4));
        end
        got++;
      end
      if (acc) begin
        full4 = {1'b0, a4} + {1'b0, b4} + {4'h0, cin4};
        exp4 = {(a4[3] == b4[3]) && (full4[3] != a4[3]), full4};
        exp_q.push_back(exp4);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    check_val("exh_count", 32'(got), 32'd512);
    check_val("exh_sent", 32'(sent), 32'd512);
    check_val("exh_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
